// File: rtl/bp_me_wormhole_lce_req_deserializer.sv
// CCE-side wormhole receiver: gathers coherence request flits into one
// message and hands it to the CCE over a valid/yumi interface.
module bp_me_wormhole_lce_req_deserializer #(
    parameter int coh_noc_flit_width_p = 64,
    parameter int coh_noc_cord_width_p = 8,
    parameter int coh_noc_len_width_p  = 4,
    parameter int coh_noc_cid_width_p  = 2,
    parameter int lce_cce_req_width_p  = 560
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [coh_noc_flit_width_p-1:0] link_data_i,
    input  logic                            link_v_i,
    output logic                            link_ready_and_o,
    output logic [lce_cce_req_width_p-1:0]  lce_req_o,
    output logic                            lce_req_v_o,
    input  logic                            lce_req_yumi_i
);

    localparam int fw_lp        = coh_noc_flit_width_p;
    localparam int hdr_w_lp     = coh_noc_cord_width_p
                                + coh_noc_len_width_p
                                + coh_noc_cid_width_p;
    localparam int pkt_w_lp     = hdr_w_lp + lce_cce_req_width_p;
    localparam int max_flits_lp = (pkt_w_lp + fw_lp - 1) / fw_lp;

    typedef logic [coh_noc_len_width_p-1:0] len_t;

    typedef enum logic [1:0] {
        e_hdr  = 2'd0,
        e_body = 2'd1,
        e_full = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_nxt;
    len_t   r_len;
    len_t   r_cnt;
    len_t   w_flit_len;
    logic   w_accept;
    logic   w_hdr_acc;
    logic   w_body_acc;

    assign w_flit_len = link_data_i[coh_noc_cord_width_p +: coh_noc_len_width_p];
    assign w_accept   = link_v_i & link_ready_and_o;
    assign w_hdr_acc  = w_accept & (r_state == e_hdr);
    assign w_body_acc = w_accept & (r_state == e_body);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_hdr;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            e_hdr: begin
                if (w_accept) begin
                    w_state_nxt = (w_flit_len == '0) ? e_full : e_body;
                end
            end
            e_body: begin
                if (w_accept && (r_cnt == r_len)) begin
                    w_state_nxt = e_full;
                end
            end
            e_full: begin
                if (lce_req_yumi_i) begin
                    w_state_nxt = e_hdr;
                end
            end
            default: w_state_nxt = e_hdr;
        endcase
    end

    // Handshake outputs decode state only, so no input reaches them combinationally.
    always_comb begin
        link_ready_and_o = 1'b1;
        lce_req_v_o      = 1'b0;
        unique case (r_state)
            e_hdr:   link_ready_and_o = 1'b1;
            e_body:  link_ready_and_o = 1'b1;
            e_full: begin
                link_ready_and_o = 1'b0;
                lce_req_v_o      = 1'b1;
            end
            default: link_ready_and_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_hdr_acc) begin
            r_len <= w_flit_len;
            r_cnt <= len_t'(1);
        end else if (w_body_acc && (r_cnt != r_len)) begin
            r_cnt <= r_cnt + len_t'(1);
        end
    end

    // Only the payload part of each slot is stored; header bits of slot 0
    // and padding above the packet are never needed downstream.
    for (genvar k = 0; k < max_flits_lp; k++) begin : g_slot
        localparam int lo_lp = (k == 0) ? hdr_w_lp : k * fw_lp;
        localparam int hi_lp = ((k + 1) * fw_lp > pkt_w_lp)
                             ? pkt_w_lp - 1 : (k + 1) * fw_lp - 1;
        localparam int w_lp  = hi_lp - lo_lp + 1;

        logic [w_lp-1:0] r_slot;

        if (k == 0) begin : g_head
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    r_slot <= '0;
                end else if (w_hdr_acc) begin
                    r_slot <= link_data_i[hi_lp:lo_lp];
                end
            end
        end else begin : g_body
            // Cleared on every header so short packets never expose stale bytes.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    r_slot <= '0;
                end else if (w_hdr_acc) begin
                    r_slot <= '0;
                end else if (w_body_acc && (int'(r_cnt) == k)) begin
                    r_slot <= link_data_i[hi_lp-k*fw_lp:lo_lp-k*fw_lp];
                end
            end
        end

        assign lce_req_o[hi_lp-hdr_w_lp:lo_lp-hdr_w_lp] = r_slot;
    end

    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i)
        lce_req_yumi_i |-> lce_req_v_o
    );

endmodule
